// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and widths for the inter-stage pipeline registers.
// Imported by pipe_stage_skid and its helpers.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY,
        PS_FULL,
        PS_SKID
    } pipe_state_e;

    localparam int PIPE_INSTR_W = 32;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// sat_counter: saturating up-counter with synchronous enable.
// Asynchronous active-high reset clears the count.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a 1-entry skid buffer.
// Optional perf counters (stall_cycles, flush_count) under PIPE_SKID_PERF_EN.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = PIPE_INSTR_W,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    pipe_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stage_skid: CNT_W must be at least 1");
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PS_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Flush wins over every transition; an outgoing handshake still completes.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = PS_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            unique case (state_q)
                PS_EMPTY: begin
                    if (in_valid) begin
                        state_d = PS_FULL;
                        main_d  = in_data;
                    end
                end
                PS_FULL: begin
                    if (in_valid && out_ready) begin
                        main_d = in_data;
                    end else if (in_valid) begin
                        state_d = PS_SKID;
                        skid_d  = in_data;
                    end else if (out_ready) begin
                        state_d = PS_EMPTY;
                        main_d  = NOP_VALUE;
                    end
                end
                PS_SKID: begin
                    if (out_ready) begin
                        state_d = PS_FULL;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end
                end
                default: begin
                    state_d = PS_EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    // Handshake outputs come from the state register only.
    assign in_ready  = (state_q != PS_SKID);
    assign out_valid = (state_q != PS_EMPTY);
    assign out_data  = main_q;

`ifdef PIPE_SKID_PERF_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (out_valid & ~out_ready),
        .count (stall_cycles)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (flush),
        .count (flush_count)
    );
`endif

endmodule
